// File: rtl/video_pattern_gen.sv
// Parametrised video test-pattern source: free-running h/v timing counters
// drive registered fv/lv/data/counter outputs one clock behind counter state.
module video_pattern_gen #(
  parameter int H_ACTIVE      = 1920,
  parameter int H_SYNC        = 44,
  parameter int H_BACK_PORCH  = 148,
  parameter int H_FRONT_PORCH = 88,
  parameter int V_ACTIVE      = 1080,
  parameter int V_SYNC        = 5,
  parameter int V_BACK_PORCH  = 36,
  parameter int V_FRONT_PORCH = 4,
  parameter int DATA_W        = 16,
  parameter int CNT_W         = 12,
  parameter int CHECK_LOG2    = 5
) (
  input  logic              pix_clk,
  input  logic              pix_rst_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] solid_val,
  output logic              fv,
  output logic              lv,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  linecnt,
  output logic [CNT_W-1:0]  pixcnt,
  output logic [7:0]        frame_cnt
);
  localparam int H_TOTAL = H_SYNC + H_BACK_PORCH + H_ACTIVE + H_FRONT_PORCH;
  localparam int V_TOTAL = V_SYNC + V_BACK_PORCH + V_ACTIVE + V_FRONT_PORCH;
  localparam int H_START = H_SYNC + H_BACK_PORCH;
  localparam int V_START = V_SYNC + V_BACK_PORCH;
  localparam int BAR_W   = H_ACTIVE / 32'sd8;

  localparam logic [CNT_W-1:0]  H_LAST   = CNT_W'(H_TOTAL - 32'sd1);
  localparam logic [CNT_W-1:0]  V_LAST   = CNT_W'(V_TOTAL - 32'sd1);
  localparam logic [CNT_W-1:0]  H_FIRST  = CNT_W'(H_START);
  localparam logic [CNT_W-1:0]  H_END    = CNT_W'(H_START + H_ACTIVE);
  localparam logic [CNT_W-1:0]  V_FIRST  = CNT_W'(V_START);
  localparam logic [CNT_W-1:0]  V_END    = CNT_W'(V_START + V_ACTIVE);
  localparam logic [CNT_W-1:0]  SUB_LAST = CNT_W'(BAR_W - 32'sd1);
  localparam logic [DATA_W-1:0] ONES     = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] BAR_STEP = ONES / DATA_W'(3'd7);

  logic [CNT_W-1:0]  h_r, v_r, sub_r;
  logic [2:0]        bar_r;
  logic              en_r;
  logic [1:0]        mode_r;
  logic [DATA_W-1:0] solid_r;

  logic              fv_r, lv_r;
  logic [DATA_W-1:0] data_r;
  logic [CNT_W-1:0]  linecnt_r, pixcnt_r;
  logic [7:0]        frame_cnt_r;

  logic              h_last_s, v_last_s, act_pix_s, act_line_s, fv_s, lv_s;
  logic [CNT_W-1:0]  h_nxt_s, v_nxt_s, pix_s, line_s;
  logic [DATA_W-1:0] data_s;

  // next counter state and active-region decode of the current state
  always_comb begin
    h_last_s   = (h_r == H_LAST);
    v_last_s   = (v_r == V_LAST);
    h_nxt_s    = h_last_s ? {CNT_W{1'b0}} : h_r + CNT_W'(1'b1);
    if (!h_last_s) begin
      v_nxt_s = v_r;
    end else if (v_last_s) begin
      v_nxt_s = {CNT_W{1'b0}};
    end else begin
      v_nxt_s = v_r + CNT_W'(1'b1);
    end
    act_pix_s  = (h_r >= H_FIRST) && (h_r < H_END);
    act_line_s = (v_r >= V_FIRST) && (v_r < V_END);
    fv_s       = act_line_s && en_r;
    lv_s       = fv_s && act_pix_s;
    pix_s      = act_pix_s  ? h_r - H_FIRST : {CNT_W{1'b0}};
    line_s     = act_line_s ? v_r - V_FIRST : {CNT_W{1'b0}};
  end

  // pattern value for the pixel at the current counter state
  always_comb begin
    data_s = {DATA_W{1'b0}};
    if (lv_s) begin
      case (mode_r)
        2'd0:    data_s = DATA_W'(bar_r) * BAR_STEP;
        2'd1:    data_s = DATA_W'(pix_s) + DATA_W'(frame_cnt_r);
        2'd2:    data_s = solid_r;
        2'd3:    data_s = (pix_s[CHECK_LOG2] ^ line_s[CHECK_LOG2]) ? ONES : {DATA_W{1'b0}};
        default: data_s = {DATA_W{1'b0}};
      endcase
    end else begin
      data_s = {DATA_W{1'b0}};
    end
  end

  // timing counters and frame-start capture of the run-time configuration
  always_ff @(posedge pix_clk or negedge pix_rst_n) begin
    if (!pix_rst_n) begin
      h_r     <= {CNT_W{1'b0}};
      v_r     <= {CNT_W{1'b0}};
      en_r    <= 1'b0;
      mode_r  <= 2'd0;
      solid_r <= {DATA_W{1'b0}};
    end else begin
      h_r <= h_nxt_s;
      v_r <= v_nxt_s;
      if ((h_r == {CNT_W{1'b0}}) && (v_r == {CNT_W{1'b0}})) begin
        en_r    <= enable;
        mode_r  <= mode;
        solid_r <= solid_val;
      end
    end
  end

  // bar index tracks h: sub_r counts pixels within a bar, bar_r saturates at 7
  always_ff @(posedge pix_clk or negedge pix_rst_n) begin
    if (!pix_rst_n) begin
      sub_r <= {CNT_W{1'b0}};
      bar_r <= 3'd0;
    end else if (h_nxt_s == H_FIRST) begin
      sub_r <= {CNT_W{1'b0}};
      bar_r <= 3'd0;
    end else if (sub_r == SUB_LAST) begin
      sub_r <= {CNT_W{1'b0}};
      if (bar_r != 3'd7) begin
        bar_r <= bar_r + 3'd1;
      end
    end else begin
      sub_r <= sub_r + CNT_W'(1'b1);
    end
  end

  // registered outputs; frame counter steps on the fv falling edge
  always_ff @(posedge pix_clk or negedge pix_rst_n) begin
    if (!pix_rst_n) begin
      fv_r        <= 1'b0;
      lv_r        <= 1'b0;
      data_r      <= {DATA_W{1'b0}};
      pixcnt_r    <= {CNT_W{1'b0}};
      linecnt_r   <= {CNT_W{1'b0}};
      frame_cnt_r <= 8'd0;
    end else begin
      fv_r      <= fv_s;
      lv_r      <= lv_s;
      data_r    <= data_s;
      pixcnt_r  <= pix_s;
      linecnt_r <= line_s;
      if (fv_r && !fv_s) begin
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end
    end
  end

  assign fv        = fv_r;
  assign lv        = lv_r;
  assign data      = data_r;
  assign pixcnt    = pixcnt_r;
  assign linecnt   = linecnt_r;
  assign frame_cnt = frame_cnt_r;

endmodule
